// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: shared types and constants for the PLL reconfiguration sequencer.
//   seq_state_t  - sequencer state encoding
//   cfg_entry_t  - one profile-table word {addr, data}
//   REG_*        - reconfig register addresses of the fractional PLL
package pll_cfg_pkg;

    localparam int CFG_ADDR_W = 6;
    localparam int CFG_DATA_W = 32;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        START,
        LOAD,
        WRITE,
        LOCK,
        FIN
    } seq_state_t;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
    } cfg_entry_t;

    localparam logic [CFG_ADDR_W-1:0] REG_MODE  = 6'd0;
    localparam logic [CFG_ADDR_W-1:0] REG_START = 6'd2;
    localparam logic [CFG_ADDR_W-1:0] REG_N     = 6'd3;
    localparam logic [CFG_ADDR_W-1:0] REG_M     = 6'd4;
    localparam logic [CFG_ADDR_W-1:0] REG_C     = 6'd5;
    localparam logic [CFG_ADDR_W-1:0] REG_MFRAC = 6'd7;
    localparam logic [CFG_ADDR_W-1:0] REG_BW    = 6'd8;
    localparam logic [CFG_ADDR_W-1:0] REG_CP    = 6'd9;

endpackage

// File: rtl/pll_cfg_seq_if.sv
// pll_cfg_seq_if: Avalon-MM write-only link to the PLL reconfig block.
//   cfg_write, cfg_address, cfg_writedata - driven by the sequencer (master)
//   cfg_waitrequest                       - driven by the reconfig block (slave)
interface pll_cfg_seq_if
    import pll_cfg_pkg::*;
#(
    parameter int ADDR_W = CFG_ADDR_W,
    parameter int DATA_W = CFG_DATA_W
) ();

    logic              cfg_write;
    logic [ADDR_W-1:0] cfg_address;
    logic [DATA_W-1:0] cfg_writedata;
    logic              cfg_waitrequest;

    modport master (
        output cfg_write,
        output cfg_address,
        output cfg_writedata,
        input  cfg_waitrequest
    );

    modport slave (
        input  cfg_write,
        input  cfg_address,
        input  cfg_writedata,
        output cfg_waitrequest
    );

endinterface

// File: rtl/pll_cfg_sync.sv
// pll_cfg_sync: W-bit two-flop synchroniser into the mgmt_clk domain.
//   mgmt_clk, reset (async, active-high) - clock / reset
//   d - asynchronous input, q - synchronised output (second stage)
module pll_cfg_sync #(
    parameter int W = 1
) (
    input  logic         mgmt_clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge mgmt_clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq: streams the selected clock profile's register words from an
// external combinational ROM into the PLL reconfig port, after reset and on
// every change of the synchronised profile select (or on force_update).
//   mgmt_clk, reset      - management clock, async active-high reset
//   profile_sel          - requested profile (async)
//   force_update         - 1-cycle pulse, rewrite the current profile
//   tbl_profile/index    - ROM lookup; tbl_entry {addr,data} and tbl_last return
//   cfg                  - Avalon-MM master to the reconfig block
//   pll_locked           - PLL lock (async, used only with PLL_CFG_LOCK_WAIT_EN)
//   busy, done, active_profile, error - status
// Build option: PLL_CFG_LOCK_WAIT_EN adds the LOCK state that waits for
// pll_locked after the last word, with a LOCK_TMO cycle timeout.
//
// state | meaning
// SYNC  | post-reset, let the synchronisers fill, then apply current profile
// IDLE  | waiting for a select change or force request
// START | capture profile, clear index and error
// LOAD  | register ROM word onto the Avalon bus
// WRITE | hold the word until accepted (waitrequest low)
// LOCK  | wait for PLL lock after the last word (optional)
// FIN   | publish active_profile, pulse done
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int NUM_PROFILES = 4,
    parameter int MAX_WORDS    = 16,
    parameter int ADDR_W       = CFG_ADDR_W,
    parameter int DATA_W       = CFG_DATA_W,
    parameter int LOCK_TMO     = 65535,
    localparam int PW = $clog2(NUM_PROFILES),
    localparam int IW = $clog2(MAX_WORDS)
) (
    input  logic                     mgmt_clk,
    input  logic                     reset,
    input  logic [PW-1:0]            profile_sel,
    input  logic                     force_update,
    output logic [PW-1:0]            tbl_profile,
    output logic [IW-1:0]            tbl_index,
    input  logic [ADDR_W+DATA_W-1:0] tbl_entry,
    input  logic                     tbl_last,
    pll_cfg_seq_if.master            cfg,
    input  logic                     pll_locked,
    output logic                     busy,
    output logic                     done,
    output logic [PW-1:0]            active_profile,
    output logic                     error
);

    seq_state_t    state, state_nxt;
    logic [PW-1:0] sel_s, sel_q;
    logic          sync_cnt;
    logic          last_q;
    logic          force_pend;
    logic          accept;

    pll_cfg_sync #(.W(PW)) u_sync_sel (
        .mgmt_clk (mgmt_clk),
        .reset    (reset),
        .d        (profile_sel),
        .q        (sel_s)
    );

`ifdef PLL_CFG_LOCK_WAIT_EN
    localparam int LW = $clog2(LOCK_TMO + 1);
    logic          locked_s;
    logic [LW-1:0] lock_cnt;
    logic          lock_ok, lock_tmo;

    pll_cfg_sync #(.W(1)) u_sync_lock (
        .mgmt_clk (mgmt_clk),
        .reset    (reset),
        .d        (pll_locked),
        .q        (locked_s)
    );

    // lock_cnt counts down from LOCK_TMO-1; the first 4 LOCK cycles are a
    // blanking window while the PLL drops lock after reconfiguration.
    assign lock_tmo = (lock_cnt == '0);
    assign lock_ok  = locked_s && (lock_cnt <= LW'(LOCK_TMO - 5));
`else
    logic unused_locked;
    localparam int unused_lock_tmo = LOCK_TMO;
    assign unused_locked = pll_locked;
`endif

    assign accept = cfg.cfg_write & ~cfg.cfg_waitrequest;
    assign busy   = (state != IDLE);
    assign done   = (state == FIN);

    always_ff @(posedge mgmt_clk or posedge reset) begin
        if (reset) state <= SYNC;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:  if (sync_cnt == 1'b0) state_nxt = START;
            IDLE:  if (sel_s != sel_q || force_update || force_pend) state_nxt = START;
            START: state_nxt = LOAD;
            LOAD:  state_nxt = WRITE;
            WRITE: begin
                if (accept) begin
                    if (last_q) begin
`ifdef PLL_CFG_LOCK_WAIT_EN
                        state_nxt = LOCK;
`else
                        state_nxt = FIN;
`endif
                    end else if (tbl_index == IW'(MAX_WORDS - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
`ifdef PLL_CFG_LOCK_WAIT_EN
            LOCK: begin
                if (lock_ok)       state_nxt = FIN;
                else if (lock_tmo) state_nxt = IDLE;
            end
`endif
            FIN:     state_nxt = IDLE;
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge mgmt_clk or posedge reset) begin
        if (reset) begin
            sync_cnt          <= 1'b1;
            sel_q             <= '0;
            tbl_profile       <= '0;
            tbl_index         <= '0;
            last_q            <= 1'b0;
            force_pend        <= 1'b0;
            error             <= 1'b0;
            active_profile    <= '0;
            cfg.cfg_write     <= 1'b0;
            cfg.cfg_address   <= '0;
            cfg.cfg_writedata <= '0;
`ifdef PLL_CFG_LOCK_WAIT_EN
            lock_cnt          <= '0;
`endif
        end else begin
            // A force that arrives while busy is remembered and serviced from IDLE.
            if (force_update && state != IDLE) force_pend <= 1'b1;
            case (state)
                SYNC: sync_cnt <= 1'b0;
                START: begin
                    sel_q       <= sel_s;
                    tbl_profile <= sel_s;
                    tbl_index   <= '0;
                    error       <= 1'b0;
                    if (!force_update) force_pend <= 1'b0;
                end
                LOAD: begin
                    cfg.cfg_address   <= tbl_entry[ADDR_W+DATA_W-1 -: ADDR_W];
                    cfg.cfg_writedata <= tbl_entry[DATA_W-1:0];
                    last_q            <= tbl_last;
                    cfg.cfg_write     <= 1'b1;
                end
                WRITE: begin
                    if (accept) begin
                        cfg.cfg_write <= 1'b0;
                        if (!last_q) begin
                            if (tbl_index == IW'(MAX_WORDS - 1)) error <= 1'b1;
                            else tbl_index <= tbl_index + IW'(1);
                        end
`ifdef PLL_CFG_LOCK_WAIT_EN
                        lock_cnt <= LW'(LOCK_TMO - 1);
`endif
                    end
                end
`ifdef PLL_CFG_LOCK_WAIT_EN
                LOCK: begin
                    if (!lock_tmo) lock_cnt <= lock_cnt - LW'(1);
                    if (lock_tmo && !lock_ok) error <= 1'b1;
                end
`endif
                FIN: active_profile <= tbl_profile;
                default: ;
            endcase
        end
    end

endmodule
